io_responder: RTL
=================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port mem_addr, input, 32, CPU byte address; bit 22 = IO page select, bits [4:2] = register offset.
REQ-005 SHALL have port mem_rstrb, input, 1, read strobe, one cycle wide.
REQ-006 SHALL have port mem_wdata, input, 32, write data.
REQ-007 SHALL have port mem_wmask, input, 4, byte write enables; any bit set = write request.
REQ-008 SHALL have port mem_rdata, output, 32, registered read data.
REQ-009 SHALL have port leds, output, 4, LED register.
REQ-010 SHALL have port txd, output, 1, UART serial out, idle high.

Function
REQ-011 SHALL act only on accesses with mem_addr[22]=1; accesses with mem_addr[22]=0 SHALL leave all state and mem_rdata unchanged.
REQ-012 Register map (offset = mem_addr[4:2]):
- 0 LEDS: RW, bits [3:0].
- 1 TXDATA: W, bits [7:0] = byte to send; reads 0.
- 2 STATUS: R, bit0 = busy, bit1 = overflow, other bits 0.
- 3 TXCOUNT: R, bits [7:0] = completed frames.
- Offsets 4..7: read 0, writes ignored.
REQ-013 Read latency SHALL be 1 cycle: mem_rstrb in cycle N sets mem_rdata in cycle N+1. mem_rdata SHALL hold its value until the next IO read.
REQ-014 A LEDS write SHALL update leds only when mem_wmask[0]=1, visible in cycle N+1.
REQ-015 A TXDATA write with mem_wmask[0]=1 while not busy SHALL latch mem_wdata[7:0] and start a frame; busy SHALL read 1 from cycle N+1.
REQ-016 A TXDATA write while busy SHALL be dropped, SHALL set overflow, and SHALL NOT disturb the frame in flight.
REQ-017 A STATUS read SHALL return the pre-clear value, then clear overflow. If a STATUS read and an overflow-setting write occur in the same cycle, overflow SHALL end the cycle set.
REQ-018 If mem_rstrb and mem_wmask are both active in the same cycle, the write SHALL take effect and the read SHALL return the pre-write value.
REQ-019 The TX state machine SHALL have states IDLE -> START -> DATA -> STOP -> IDLE, with each state held BAUD_DIV cycles per bit.
REQ-020 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). A frame lasts 10*BAUD_DIV cycles.
REQ-021 txd SHALL be registered, SHALL be 1 in IDLE, and the start bit SHALL begin in cycle N+1 after the accepting write.
REQ-022 busy SHALL fall in the cycle after the last stop-bit cycle; a new TXDATA write SHALL be accepted in that same cycle.
REQ-023 TXCOUNT SHALL increment at STOP -> IDLE and wrap from 255 to 0.
REQ-024 The baud counter SHALL count 0..BAUD_DIV-1, SHALL wrap to 0, and SHALL reset to 0 on every state change.

Reset
REQ-025 While reset=1: leds=0, mem_rdata=0, txd=1, state=IDLE, busy=0, overflow=0, TXCOUNT=0, baud and bit counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with txd=1 from the next cycle; no partial byte SHALL be counted.
REQ-027 Accesses presented while reset=1 SHALL be ignored.

Structure
REQ-028 Shared package io_pkg SHALL hold: IO page bit index (22), register offsets (LEDS=0, TXDATA=1, STATUS=2, TXCOUNT=3), STATUS bit positions, and the TX state encoding.
REQ-029 Serialisation (baud counter, bit counter, shift register, state machine) SHALL live in sub-module uart_tx, with ports clk, reset, start, data[7:0], busy, done, txd.
REQ-030 Register decode and the bus-side logic SHALL stay in io_responder.

Verification (BAUD_DIV=4)
REQ-031 Write 0x0000000A to addr 0x400000 with wmask=0001 -> leds=4'hA next cycle. Read addr 0x400000 -> mem_rdata=0x0000000A one cycle later.
REQ-032 Write 0x55 to 0x400004 -> txd shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 4 cycles; busy=1 for 40 cycles; TXCOUNT reads 1.
REQ-033 Write 0x41, then write 0x42 at cycle 10 of the frame -> only 0x41 is sent. STATUS reads 0x3, then 0x1 on the next read; TXCOUNT=1 after the frame.
REQ-034 Write 0x0F to LEDS with addr bit22=0 -> leds unchanged. Write with wmask=0010 -> leds unchanged.
REQ-035 Start a frame, assert reset at cycle 17 -> txd=1 next cycle, STATUS=0, TXCOUNT=0. After deassert, a new byte is sent correctly.
REQ-036 Send 256 frames -> TXCOUNT reads 0. A write issued in the first cycle busy=0 is accepted with no gap.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the IO page: address decode, register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package io_pkg;

  localparam int IO_PAGE_BIT = 22;

  localparam logic [2:0] OFF_LEDS    = 3'd0;
  localparam logic [2:0] OFF_TXDATA  = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_TXCOUNT = 3'd3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serialiser: start bit, eight data bits LSB first, stop bit,
// each held BAUD_DIV clocks. done pulses on the last stop-bit cycle.
module uart_tx
  import io_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_busy;
  logic        w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (start) begin
            r_state <= TX_START;
            r_shift <= data;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end
        TX_START: begin
          if (w_baud_end) begin
            r_state <= TX_DATA;
            r_baud  <= '0;
            r_txd   <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        TX_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= TX_STOP;
              r_bit   <= '0;
              r_txd   <= 1'b1;
            end else begin
              // Look one bit ahead so txd changes on the same edge as the shift
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        TX_STOP: begin
          if (w_baud_end) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_txd   <= 1'b1;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign txd  = r_txd;
  assign done = (r_state == TX_STOP) && w_baud_end;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO page: LED register, UART transmit data, status and a
// completed-frame counter. Reads return registered data one cycle later.
module io_responder
  import io_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic [3:0]  leds,
  output logic        txd
);

  logic [31:0] r_rdata;
  logic [3:0]  r_leds;
  logic        r_ovf;
  logic [7:0]  r_txcount;

  logic        w_sel;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_wr;
  logic        w_start;
  logic        w_ovf_set;
  logic        w_status_rd;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_sel       = mem_addr[IO_PAGE_BIT];
  assign w_off       = mem_addr[4:2];
  assign w_wr        = w_sel && (mem_wmask != 4'b0000);
  assign w_rd        = w_sel && mem_rstrb;
  assign w_tx_wr     = w_wr && (w_off == OFF_TXDATA) && mem_wmask[0];
  assign w_start     = w_tx_wr && !w_busy;
  assign w_ovf_set   = w_tx_wr && w_busy;
  assign w_status_rd = w_rd && (w_off == OFF_STATUS);

  assign w_unused = ^{mem_addr[31:23], mem_addr[21:5], mem_addr[1:0], mem_wdata[31:8]};

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .data  (mem_wdata[7:0]),
    .busy  (w_busy),
    .done  (w_done),
    .txd   (txd)
  );

  // Read mux works on current register values, so a same-cycle write is not visible
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_LEDS:    w_rd_val = {28'd0, r_leds};
      OFF_STATUS: begin
        w_rd_val[STATUS_BUSY_BIT] = w_busy;
        w_rd_val[STATUS_OVF_BIT]  = r_ovf;
      end
      OFF_TXCOUNT: w_rd_val = {24'd0, r_txcount};
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata   <= '0;
      r_leds    <= '0;
      r_ovf     <= 1'b0;
      r_txcount <= '0;
    end else begin
      if (w_rd)
        r_rdata <= w_rd_val;
      if (w_wr && (w_off == OFF_LEDS) && mem_wmask[0])
        r_leds <= mem_wdata[3:0];
      // A dropped write wins over the clear from a simultaneous STATUS read
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_status_rd)
        r_ovf <= 1'b0;
      if (w_done)
        r_txcount <= r_txcount + 8'd1;
    end
  end

  assign mem_rdata = r_rdata;
  assign leds      = r_leds;

endmodule
